// File: rtl/divider_pkg.sv
// divider_pkg
//   Definitions shared by the divider control sequencer and the remainder
//   datapath: operand width, the ALU function code that requests a trial
//   subtraction, the iteration count and the datapath operation decode.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [5:0] SUBU_FUNC = 6'b001010;
    localparam int DIV_ITERATIONS = 32;

    // Remainder-register operation selected for one clock.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_SRL,
        OP_SUB_SHIFT,
        OP_SHIFT
    } rem_op_e;

    // Resolves the control strobes into one operation.
    // Priority: load > right shift > subtract/shift > plain shift > hold.
    function automatic rem_op_e decode_op(
        input logic       w_ctrl,
        input logic       srl_ctrl,
        input logic       sll_ctrl,
        input logic [5:0] subu_ctrl
    );
        rem_op_e op;
        if (w_ctrl) begin
            op = OP_LOAD;
        end else if (srl_ctrl) begin
            op = OP_SRL;
        end else if (sll_ctrl && (subu_ctrl == SUBU_FUNC)) begin
            op = OP_SUB_SHIFT;
        end else if (sll_ctrl) begin
            op = OP_SHIFT;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/divider_subu.sv
// divider_subu
//   Trial subtractor: (W+1)-bit minuend minus W-bit subtrahend, both treated
//   as unsigned, producing a (W+2)-bit two's-complement difference whose top
//   bit is the borrow (negative result).
// Ports:
//   minuend     in  W+1  upper half of the remainder register
//   subtrahend  in  W    divisor
//   diff        out W+2  minuend - subtrahend
module divider_subu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH+1:0] diff
);

    assign diff = {1'b0, minuend} - {2'b00, subtrahend};

endmodule

// File: rtl/divider_remainder_datapath.sv
// divider_remainder_datapath
//   Restoring-division datapath for the unsigned sequential divider. Holds a
//   (2*WIDTH+1)-bit remainder register and a WIDTH-bit divisor register and
//   executes the sequencer's load / subtract-shift / shift / fix-up commands,
//   one quotient bit per clock. The sequencer sees the trial-subtraction sign
//   on MSB.
// Optional feature (macro DIV_ZERO_DETECT_EN):
//   when defined, DivZero is a registered flag updated on every load with
//   (Divisor == 0); when undefined, DivZero is tied low and no comparator exists.
// Ports:
//   clk        in   1      rising-edge clock
//   Reset_n    in   1      asynchronous active-low reset
//   Dividend   in   WIDTH  operand, sampled on load
//   Divisor    in   WIDTH  operand, sampled on load
//   W_ctrl     in   1      load operands
//   SUBU_ctrl  in   6      ALU function; SUBU_FUNC requests a trial subtract
//   SLL_ctrl   in   1      shift remainder left one bit
//   SRL_ctrl   in   1      shift upper remainder half right one bit
//   MSB        out  1      trial difference is negative (upper half < divisor)
//   Quotient   out  WIDTH  lower half of the remainder register
//   Remainder  out  WIDTH  upper half of the remainder register (low WIDTH bits)
//   DivZero    out  1      divide-by-zero flag
module divider_remainder_datapath
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             W_ctrl,
    input  logic [5:0]       SUBU_ctrl,
    input  logic             SLL_ctrl,
    input  logic             SRL_ctrl,
    output logic             MSB,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    logic [2*WIDTH:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH+1:0] trial;
    rem_op_e          op;

    // Upper half is WIDTH+1 bits wide: during the iterations it may reach
    // 2*dvs-1, so the bit shifted out of the WIDTH-bit half must be kept.
    assign upper = rem[2*WIDTH:WIDTH];
    assign lower = rem[WIDTH-1:0];

    divider_subu #(
        .WIDTH (WIDTH)
    ) u_subu (
        .minuend    (upper),
        .subtrahend (dvs),
        .diff       (trial)
    );

    // Borrow of the trial subtraction, evaluated every cycle regardless of
    // the ALU function. With dvs == 0 this is always 0.
    assign MSB = trial[WIDTH+1];

    assign op = decode_op(W_ctrl, SRL_ctrl, SLL_ctrl, SUBU_ctrl);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem <= '0;
            dvs <= '0;
        end else begin
            case (op)
                OP_LOAD: begin
                    dvs <= Divisor;
                    if (SLL_ctrl) begin
                        rem <= {{WIDTH{1'b0}}, Dividend, 1'b0};
                    end else begin
                        rem <= {{(WIDTH+1){1'b0}}, Dividend};
                    end
                end
                OP_SRL: begin
                    rem[2*WIDTH:WIDTH] <= upper >> 1;
                end
                OP_SUB_SHIFT: begin
                    // A non-negative difference is below dvs, so its low
                    // WIDTH bits carry the whole value.
                    if (trial[WIDTH+1]) begin
                        rem <= {upper[WIDTH-1:0], lower, 1'b0};
                    end else begin
                        rem <= {trial[WIDTH-1:0], lower, 1'b1};
                    end
                end
                OP_SHIFT: begin
                    rem <= {rem[2*WIDTH-1:0], 1'b0};
                end
                default: begin
                    rem <= rem;
                end
            endcase
        end
    end

    assign Quotient  = lower;
    assign Remainder = rem[2*WIDTH-1:WIDTH];

`ifdef DIV_ZERO_DETECT_EN
    logic div_zero;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_zero <= 1'b0;
        end else if (W_ctrl) begin
            div_zero <= (Divisor == '0);
        end
    end

    assign DivZero = div_zero;
`else
    assign DivZero = 1'b0;
`endif

endmodule

// File: doc/divider_remainder_datapath.md
# divider_remainder_datapath

- Datapath stage for the 32-bit unsigned sequential divider. It sits directly downstream of the divider control sequencer and executes its `W_ctrl` / `SUBU_ctrl` / `SLL_ctrl` / `SRL_ctrl` commands on a 65-bit remainder register and a 32-bit divisor register.
- It returns the sign flag `MSB` to the sequencer.
- It implements restoring division, one quotient bit per clock, and exposes quotient and remainder once the sequencer signals completion.

## Interface
- `WIDTH`, default 32: dividend/divisor width; internal remainder register is 2*WIDTH+1 bits.
- `clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `Dividend`  in  WIDTH  operand, sampled when `W_ctrl`=1.
- `Divisor`  in  WIDTH  operand, sampled when `W_ctrl`=1.
- `W_ctrl`  in  1  load operands.
- `SUBU_ctrl`  in  6  ALU function; `6'b001010` = SUBU, all other codes = no subtract.
- `SLL_ctrl`  in  1  shift remainder left one bit.
- `SRL_ctrl`  in  1  shift upper remainder half right one bit (final fix-up).
- `MSB`  out  1  combinational: 1 when the trial subtraction is negative (upper half < divisor).
- `Quotient`  out  WIDTH  `Rem[WIDTH-1:0]`.
- `Remainder`  out  WIDTH  `Rem[2*WIDTH-1:WIDTH]`.
- `DivZero`  out  1  registered divide-by-zero flag (only with macro, see Configuration).

## Operation
- State: `Rem[2W:0]` (upper part `U = Rem[2W:W]`, W+1 bits; lower part `L = Rem[W-1:0]`), `Dvs[W-1:0]`.
- Trial difference `T = {1'b0,U} - {2'b0,Dvs}`, W+2 bits.
- `MSB = T[W+1]`. It is evaluated every cycle, independent of `SUBU_ctrl`.
- Per-clock update, priority order:
  - `W_ctrl`=1: `Dvs <= Divisor`. With `SLL_ctrl`=1, `Rem <= {W'b0, Dividend, 1'b0}`; otherwise `Rem <= {(W+1)'b0, Dividend}`. SUBU/SRL are ignored.
  - `SRL_ctrl`=1: `U <= U >> 1`, zero fill; `L` unchanged.
  - `SLL_ctrl`=1 and `SUBU_ctrl`==SUBU:
    - `MSB`=0: `Rem <= {T[W-1:0], L, 1'b1}` (subtract, shift, insert 1).
    - `MSB`=1: `Rem <= {U[W-1:0], L, 1'b0}` (restore, shift, insert 0).
  - `SLL_ctrl`=1, other SUBU code: plain left shift inserting 0.
  - Otherwise: hold.
- Full division sequence: one load cycle with `SLL_ctrl`=1, then 32 SUBU+SLL cycles, then one SRL cycle. Result: `Quotient`=floor(Dividend/Divisor), `Remainder`=Dividend mod Divisor.
- `U` is W+1 bits so the bit shifted out of the upper half is never lost (`U` < 2*Dvs always holds).
- Divisor 0: `MSB` is always 0. Result is `Quotient`=all ones and `Remainder`=Dividend; this is defined behaviour, not an error.

## Timing
- Reset (`Reset_n`=0, asynchronous): `Rem`=0, `Dvs`=0. Outputs reset to `Quotient`=0, `Remainder`=0, `DivZero`=0, and `MSB`=0.
- Control inputs are registered outputs of the sequencer and act on the same rising edge they are presented for.
- `MSB` is valid combinationally in the cycle after each update and is consumed by the sequencer on the next edge.
- Latency: 34 clocks from load edge to valid `Quotient`/`Remainder`. Outputs hold until the next `W_ctrl`.
- Reset mid-operation: immediate clear. No partial result is retained.
- `W_ctrl` asserted mid-division: reload wins. The prior division is abandoned.
- `SRL_ctrl` and `SLL_ctrl` both 1: SRL wins.

## Configuration
- `DIV_ZERO_DETECT_EN` defined:
  - `DivZero` is set on a load edge with `Divisor`==0 and cleared on a load with nonzero `Divisor`.
  - Datapath results are unchanged.
- Not defined: the `DivZero` port exists and is tied 0, and no comparator is built.

## Structure
- Shared package `divider_pkg`: `DIV_WIDTH`=32, `SUBU_FUNC`=`6'b001010`, iteration count 32.
- The sequencer uses the same package.
- Sub-module `divider_subu`: (W+1)-bit minus W-bit subtractor returning W+2-bit difference. It is instantiated once for `T`.

## Test plan
- Reset, then 100/7 through the full sequence -> after 34 clocks `Quotient`=14, `Remainder`=2.
- 0xFFFFFFFF/1 -> `Quotient`=0xFFFFFFFF, `Remainder`=0; checks the W+1 upper-half carry.
- 5/10 -> `Quotient`=0, `Remainder`=5. `MSB`=1 on every iteration except none (all restore).
- 0x12345678/0, with macro -> `DivZero`=1, `Quotient`=0xFFFFFFFF, `Remainder`=0x12345678. Without macro, `DivZero`=0.
- Deassert `Reset_n` asynchronously after iteration 10 of 1000/3 -> all outputs 0 immediately. A reload of 1000/3 then yields 333 r 1.
- `W_ctrl`=1 concurrent with `SRL_ctrl`=1 and SUBU: 9/4 -> load wins; subsequent sequence gives 2 r 1.
